axi_lite_arbiter: RTL

Two-master, one-slave AXI-lite arbiter that shares the data SRAM port between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read/write). It sits between the IFU/LSU bus interfaces and the SRAM slave. It serialises accesses: one transaction is outstanding at a time, and the grant is held from address handshake to response handshake. Arbitration is fixed-priority by default, or round-robin when configured.

---
 rtl/axi_lite_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: two-master (IFU read-only, LSU read/write) to one-slave
// AXI-lite arbiter. One transaction in flight; the grant is held from the
// address phase through the response handshake, with one IDLE cycle between.
// Optional macro ARB_RR_EN: round-robin M0/M1 instead of fixed LSU priority.
module axi_lite_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   // IFU (master 0)
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   // LSU (master 1)
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   // SRAM slave
   output logic [ADDR_W-1:0]   s_araddr,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B} state_t;
   typedef enum logic [1:0] {GNT_NONE, GNT_M0, GNT_M1} gnt_t;

   state_t state;
   gnt_t   gnt;

   logic r0, r1, w1;
   logic win_m0, win_m1;

   assign r0 = m0_arvalid;
   assign r1 = m1_arvalid;
   assign w1 = m1_awvalid && m1_wvalid;

`ifdef ARB_RR_EN
   // 0: M0 has priority next, 1: M1 has priority next
   logic rr_ptr;

   // Round-robin pick: the master granted last yields when both request
   always_comb begin
      win_m0 = r0 && (!(r1 || w1) || !rr_ptr);
      win_m1 = (r1 || w1) && !win_m0;
   end
`else
   // Fixed priority pick: the LSU always wins over the IFU
   always_comb begin
      win_m1 = r1 || w1;
      win_m0 = r0 && !win_m1;
   end
`endif

   // Transaction FSM and grant register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         gnt    <= GNT_NONE;
`ifdef ARB_RR_EN
         rr_ptr <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (win_m1) begin
                  gnt   <= GNT_M1;
                  state <= w1 ? WR_A : RD_A;   // LSU write beats LSU read
`ifdef ARB_RR_EN
                  rr_ptr <= 1'b0;
`endif
               end else if (win_m0) begin
                  gnt   <= GNT_M0;
                  state <= RD_A;
`ifdef ARB_RR_EN
                  rr_ptr <= 1'b1;
`endif
               end
            end
            RD_A: if (s_arvalid && s_arready) state <= RD_D;
            RD_D: if (s_rvalid && s_rready) begin
               state <= IDLE;
               gnt   <= GNT_NONE;
            end
            WR_A: if (s_awvalid && s_awready && s_wvalid && s_wready) state <= WR_B;
            WR_B: if (s_bvalid && s_bready) begin
               state <= IDLE;
               gnt   <= GNT_NONE;
            end
            default: begin
               state <= IDLE;
               gnt   <= GNT_NONE;
            end
         endcase
      end
   end

   // Channel routing from the registered state/grant; everything else is 0
   always_comb begin
      m0_arready = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = '0;
      m0_rvalid  = 1'b0;
      m1_arready = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = '0;
      m1_rvalid  = 1'b0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bresp   = '0;
      m1_bvalid  = 1'b0;
      s_araddr   = '0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      s_awaddr   = '0;
      s_awvalid  = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      case (state)
         RD_A: begin
            if (gnt == GNT_M1) begin
               s_araddr   = m1_araddr;
               s_arvalid  = m1_arvalid;
               m1_arready = s_arready;
            end else if (gnt == GNT_M0) begin
               s_araddr   = m0_araddr;
               s_arvalid  = m0_arvalid;
               m0_arready = s_arready;
            end
         end
         RD_D: begin
            if (gnt == GNT_M1) begin
               m1_rdata  = s_rdata;
               m1_rresp  = s_rresp;
               m1_rvalid = s_rvalid;
               s_rready  = m1_rready;
            end else if (gnt == GNT_M0) begin
               m0_rdata  = s_rdata;
               m0_rresp  = s_rresp;
               m0_rvalid = s_rvalid;
               s_rready  = m0_rready;
            end
         end
         WR_A: begin
            // AW and W travel together so both handshakes land in one cycle
            s_awaddr   = m1_awaddr;
            s_awvalid  = m1_awvalid;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            s_wvalid   = m1_wvalid;
            m1_awready = s_awready && s_wready;
            m1_wready  = s_awready && s_wready;
         end
         WR_B: begin
            m1_bresp  = s_bresp;
            m1_bvalid = s_bvalid;
            s_bready  = m1_bready;
         end
         default: ;
      endcase
   end

endmodule
